// File: rtl/mips_pkg.sv
// Shared types and constants for the memory arbiter.
package mips_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned TMO_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/tmo_counter.sv
// Busy-cycle counter with a registered terminal-count flag at TMO-1.
module tmo_counter #(
    parameter int unsigned TMO = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW   = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [CW-1:0] LAST = CW'(TMO - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tc_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // tc is precomputed from the next count so it is valid in the cycle the count reaches LAST
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= (cnt_d == LAST);
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (I) and data (D) requests onto a single memory port with timeout.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned N   = 64,
    parameter int unsigned TMO = TMO_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ireq,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              idone,
    output logic [INSTR_W-1:0] irdata,
    output logic              istall,
    input  logic              dreq,
    input  logic              dwe,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [N-1:0]      dwdata,
    output logic              ddone,
    output logic [N-1:0]      drdata,
    output logic              dstall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [N-1:0]      mem_wdata,
    input  logic [N-1:0]      mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    arb_state_e state_q, state_d;

    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [N-1:0]       mem_wdata_q, mem_wdata_d;
    logic               idone_q, idone_d;
    logic               ddone_q, ddone_d;
    logic [INSTR_W-1:0] irdata_q, irdata_d;
    logic [N-1:0]       drdata_q, drdata_d;
    logic               err_q, err_d;

    logic idle, busy, grant_d, grant_i, tc, cnt_clr, cnt_en;

    // A port is not re-granted during its own done cycle; D has priority
    assign idle    = (state_q == IDLE);
    assign busy    = ~idle;
    assign grant_d = idle & dreq & ~ddone_q;
    assign grant_i = idle & ireq & ~idone_q & ~grant_d;
    assign cnt_clr = grant_d | grant_i;
    assign cnt_en  = busy & ~mem_ready & ~tc;

    tmo_counter #(
        .TMO (TMO)
    ) u_tmo (
        .clk   (clk),
        .reset (reset),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = DBUSY;
                end else if (grant_i) begin
                    state_d = IBUSY;
                end
            end
            IBUSY, DBUSY: begin
                if (mem_ready || tc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // mem_ready wins over a coincident timeout
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        idone_d     = 1'b0;
        ddone_d     = 1'b0;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
        err_d       = err_q;
        if (grant_d) begin
            mem_req_d   = 1'b1;
            mem_we_d    = dwe;
            mem_addr_d  = daddr;
            mem_wdata_d = dwdata;
        end else if (grant_i) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = iaddr;
        end else if (busy && (mem_ready || tc)) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            idone_d   = (state_q == IBUSY);
            ddone_d   = (state_q == DBUSY);
            if (mem_ready) begin
                if (state_q == IBUSY) begin
                    irdata_d = mem_addr_q[2] ? mem_rdata[2*INSTR_W-1:INSTR_W]
                                             : mem_rdata[INSTR_W-1:0];
                end else begin
                    drdata_d = mem_rdata;
                end
            end else begin
                err_d = 1'b1;
                if (state_q == IBUSY) begin
                    irdata_d = '0;
                end else begin
                    drdata_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            idone_q     <= 1'b0;
            ddone_q     <= 1'b0;
            irdata_q    <= '0;
            drdata_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            idone_q     <= idone_d;
            ddone_q     <= ddone_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign idone     = idone_q;
    assign ddone     = ddone_q;
    assign irdata    = irdata_q;
    assign drdata    = drdata_q;
    assign err       = err_q;
    assign istall    = ireq & ~idone_q;
    assign dstall    = dreq & ~ddone_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 64, meaning data/memory word width in bits.
REQ-002 The block SHALL have parameter TMO, default 16, meaning the memory-response timeout in cycles.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port ireq  input  1  fetch-side request, held high until idone.
REQ-006 The block SHALL have port iaddr  input  32  fetch byte address.
REQ-007 The block SHALL have port idone  output  1  one-cycle fetch-completion pulse.
REQ-008 The block SHALL have port irdata  output  32  fetched instruction, valid while idone is high.
REQ-009 The block SHALL have port istall  output  1  fetch stall, equal to ireq & ~idone.
REQ-010 The block SHALL have port dreq  input  1  data-side request, held high until ddone.
REQ-011 The block SHALL have port dwe  input  1  data write enable, qualified by dreq.
REQ-012 The block SHALL have port daddr  input  32  data byte address.
REQ-013 The block SHALL have port dwdata  input  N  store data.
REQ-014 The block SHALL have port ddone  output  1  one-cycle data-completion pulse.
REQ-015 The block SHALL have port drdata  output  N  load data, valid while ddone is high.
REQ-016 The block SHALL have port dstall  output  1  data stall, equal to dreq & ~ddone.
REQ-017 The block SHALL have port mem_req  output  1  memory request, held until accepted.
REQ-018 The block SHALL have port mem_we  output  1  memory write enable.
REQ-019 The block SHALL have port mem_addr  output  32  memory byte address.
REQ-020 The block SHALL have port mem_wdata  output  N  memory write data.
REQ-021 The block SHALL have port mem_rdata  input  N  memory read data, valid with mem_ready.
REQ-022 The block SHALL have port mem_ready  input  1  memory completion, sampled only while mem_req is high.
REQ-023 The block SHALL have port err  output  1  sticky timeout flag.

Function
REQ-024 The FSM SHALL have exactly three states, IDLE, IBUSY and DBUSY, and SHALL leave IDLE only on an edge that grants a port.
REQ-025 In IDLE, the grant SHALL go to D if dreq is high, otherwise to I if ireq is high; when both are high, D wins and I stays stalled.
REQ-026 In IDLE, no grant SHALL be made to a port whose done signal is high in that cycle; a request still held during its own done cycle is not re-granted.
REQ-027 A grant SHALL register mem_req=1 together with mem_addr, mem_we and mem_wdata; for I, mem_we=0 and mem_addr=iaddr; for D, mem_we=dwe, mem_addr=daddr and mem_wdata=dwdata.
REQ-028 mem_addr, mem_we and mem_wdata SHALL stay stable while mem_req is high.
REQ-029 In IBUSY or DBUSY with mem_ready=1, the next edge SHALL:
  - capture the result (irdata = mem_rdata[31:0] if mem_addr[2]=0, else mem_rdata[63:32]; drdata = mem_rdata);
  - pulse the matching done signal for exactly one cycle;
  - clear mem_req and return to IDLE.
REQ-030 Minimum latency SHALL be: request sampled at edge k, mem_req high in cycle k, done high in cycle k+1 (given mem_ready in cycle k); consecutive grants therefore SHALL be at least 2 cycles apart.
REQ-031 A cycle counter SHALL clear on each grant and increment each busy cycle that has no mem_ready.
REQ-032 When that counter reaches TMO-1 without mem_ready, the next edge SHALL abort the access:
  - done pulses with read data forced to 0;
  - err is set and stays set until reset;
  - mem_req clears and the FSM returns to IDLE.
REQ-033 mem_ready arriving in the same cycle the timeout fires SHALL win: normal completion, no err.
REQ-034 mem_ready while mem_req=0 SHALL be ignored.
REQ-035 Write completions SHALL still pulse ddone; drdata is don't-care for writes.

Reset
REQ-036 With reset=0 at an edge, the block SHALL force:
  - FSM to IDLE, counter to 0;
  - mem_req, mem_we, idone, ddone and err to 0;
  - mem_addr, mem_wdata, irdata and drdata to 0.
REQ-037 A reset asserted mid-access SHALL abort without any done pulse; istall and dstall remain combinational from ireq/dreq.

Structure
REQ-038 The state enum (IDLE/IBUSY/DBUSY) and the TMO default SHALL live in the shared package mips_pkg.
REQ-039 The timeout counter SHALL be the single sub-module, tmo_counter (clear, enable, terminal-count output).

Verification
REQ-040 The bench SHALL cover fetch only: ireq=1, iaddr=0x104, mem_ready in the first busy cycle, mem_rdata=0xAAAA_BBBB_1111_2222 -> idone exactly one cycle later, irdata=0xAAAABBBB.
REQ-041 The bench SHALL cover a simultaneous request: ireq and dreq both high, dwe=1, daddr=0x40, dwdata=0x5 -> D granted first with mem_we=1, ddone, then I granted 2 cycles after the D grant, and istall high throughout.
REQ-042 The bench SHALL cover a slow memory: mem_ready delayed 5 cycles -> mem_req and mem_addr stable for 6 cycles, done on the 7th, err=0.
REQ-043 The bench SHALL cover timeout: mem_ready never arrives with TMO=16 -> done with 0 data 16 cycles after the grant, err=1 held until reset.
REQ-044 The bench SHALL cover ready at the timeout boundary: mem_ready in the cycle the counter equals 15 -> normal data returned, err=0.
REQ-045 The bench SHALL cover reset mid-access: reset=0 during DBUSY -> mem_req=0 and no ddone next cycle; after release, a held dreq is re-granted.
